magic_nmi_ctrl: RTL and testbench

Parametrised service-mode controller for the CPLD: latches up to NSRC NMI request sources and raises /NMI on the frame-interrupt edge. It maps the service ROM on the 0x0066 entry fetch and validates it by a signature opcode, then handles exit and remap traps. It also exposes an NREG-deep, read/write configuration register file on a single I/O port. A watchdog releases /NMI if the CPU never takes the entry fetch. It sits between the cpu_bus and the memory/peripheral decoders.

---
 rtl/magic_nmi_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_magic_nmi_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/magic_nmi_ctrl.sv
// magic_nmi_ctrl: service-mode (magic button) controller for the CPLD.
// Latches NMI requests on the frame-interrupt edge, maps the service ROM at
// the 0x0066 entry fetch, validates it by its first opcode, handles the
// exit/remap traps and exposes a small I/O-mapped configuration register file.
module magic_nmi_ctrl #(
  parameter int                 NSRC     = 2,
  parameter int                 NREG     = 12,
  parameter logic [NREG*8-1:0]  CFG_RST  = '0,
  parameter logic [7:0]         CFG_PORT = 8'hFF,
  parameter logic [7:0]         SIG      = 8'hEB,
  parameter logic [15:0]        EXIT_A   = 16'hF000,
  parameter logic [15:0]        REMAP_A  = 16'hF008,
  parameter int                 WDOG     = 3
) (
  input  logic              clk28,
  input  logic              rst_n,
  input  logic              mreq_i,
  input  logic              ioreq_i,
  input  logic              m1_i,
  input  logic              rd_i,
  input  logic              wr_i,
  input  logic [15:0]       a_i,
  input  logic [7:0]        d_i,
  input  logic              n_int_i,
  input  logic              n_int_next_i,
  input  logic [NSRC-1:0]   req_i,
  input  logic [3:0]        aux_st_i,
  output logic [7:0]        d_out_o,
  output logic              d_out_active_o,
  output logic              n_nmi_o,
  output logic              magic_mode_o,
  output logic              magic_map_o,
  output logic [2:0]        cause_o,
  output logic [NREG*8-1:0] cfg_q_o
);

  localparam int WW = (WDOG < 2) ? 1 : $clog2(WDOG + 1);

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    SIGCHK,
    ACTIVE,
    UNMAP,
    REARM
  } state_t;

  state_t            state_q, state_d;
  logic              nNmi_q, nNmi_d;
  logic              magicMode_q, magicMode_d;
  logic              magicMap_q, magicMap_d;
  logic [2:0]        cause_q, cause_d;
  logic [WW-1:0]     wdog_q, wdog_d;
  logic              rearm_q, rearm_d;
  logic              fetchSeen_q, fetchSeen_d;
  logic              sigOk_q, sigOk_d;
  logic [NREG*8-1:0] cfg_q, cfg_d;
  logic [7:0]        dOut_q, dOut_d;
  logic              dOutActive_q, dOutActive_d;

  logic       frameEdge;
  logic       opFetch;
  logic       memRead;
  logic       cfgSel;
  logic [7:0] cfgIdx;
  logic [2:0] prioIdx;
  logic [7:0] readData;

  assign frameEdge = n_int_i && !n_int_next_i;
  assign opFetch   = m1_i && mreq_i && rd_i;
  assign memRead   = mreq_i && rd_i;
  assign cfgSel    = magicMap_q && ioreq_i && (a_i[7:0] == CFG_PORT);
  assign cfgIdx    = a_i[15:8];

  // Pick the lowest-numbered active request source (bit 0 wins).
  always_comb begin
    prioIdx = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) prioIdx = 3'(i);
    end
  end

  // Session sequencing: next state and registered control outputs.
  always_comb begin
    state_d     = state_q;
    nNmi_d      = nNmi_q;
    magicMode_d = magicMode_q;
    magicMap_d  = magicMap_q;
    cause_d     = cause_q;
    wdog_d      = wdog_q;
    rearm_d     = rearm_q;
    fetchSeen_d = fetchSeen_q;
    sigOk_d     = sigOk_q;
    case (state_q)
      IDLE: begin
        if (frameEdge && (|req_i) && !magicMode_q) begin
          cause_d     = prioIdx;
          nNmi_d      = 1'b0;
          magicMode_d = 1'b1;
          wdog_d      = '0;
          state_d     = PEND;
        end
      end
      PEND: begin
        if (m1_i && mreq_i && (a_i == 16'h0066)) begin
          nNmi_d      = 1'b1;
          magicMap_d  = 1'b1;
          fetchSeen_d = 1'b0;
          state_d     = SIGCHK;
        end else if ((WDOG != 0) && frameEdge) begin
          if (int'(wdog_q) + 1 >= WDOG) begin
            nNmi_d      = 1'b1;
            magicMode_d = 1'b0;
            state_d     = IDLE;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
      end
      SIGCHK: begin
        if (!fetchSeen_q) begin
          if (opFetch) begin
            fetchSeen_d = 1'b1;
            sigOk_d     = (d_i == SIG);
          end
        end else if (!opFetch) begin
          fetchSeen_d = 1'b0;
          if (sigOk_q) begin
            state_d = ACTIVE;
          end else begin
            magicMode_d = 1'b0;
            magicMap_d  = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      ACTIVE: begin
        if (memRead && (a_i == EXIT_A)) begin
          magicMode_d = 1'b0;
          rearm_d     = 1'b0;
          state_d     = UNMAP;
        end else if (memRead && (a_i == REMAP_A)) begin
          rearm_d = 1'b1;
          state_d = UNMAP;
        end
      end
      UNMAP: begin
        if (!mreq_i) begin
          magicMap_d = 1'b0;
          state_d    = rearm_q ? REARM : IDLE;
        end
      end
      REARM: begin
        if (m1_i && mreq_i) begin
          magicMap_d = 1'b1;
          state_d    = ACTIVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Session state register; reset boots straight into a mapped service session.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SIGCHK;
      nNmi_q      <= 1'b1;
      magicMode_q <= 1'b1;
      magicMap_q  <= 1'b1;
      cause_q     <= 3'd0;
      wdog_q      <= '0;
      rearm_q     <= 1'b0;
      fetchSeen_q <= 1'b0;
      sigOk_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      nNmi_q      <= nNmi_d;
      magicMode_q <= magicMode_d;
      magicMap_q  <= magicMap_d;
      cause_q     <= cause_d;
      wdog_q      <= wdog_d;
      rearm_q     <= rearm_d;
      fetchSeen_q <= fetchSeen_d;
      sigOk_q     <= sigOk_d;
    end
  end

  // Config writes: port index k selects register k-1; k=0 and out-of-range are dropped.
  always_comb begin
    cfg_d = cfg_q;
    if (cfgSel && wr_i) begin
      for (int i = 0; i < NREG; i++) begin
        if (cfgIdx == 8'(i + 1)) cfg_d[8*i +: 8] = d_i;
      end
    end
  end

  // Config read mux: index 0 is the status byte, unknown indices read as 0xFF.
  always_comb begin
    readData = 8'hFF;
    if (cfgIdx == 8'd0) begin
      readData = {aux_st_i, cause_q, |req_i};
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (cfgIdx == 8'(i + 1)) readData = cfg_q[8*i +: 8];
      end
    end
  end

  // Read data is captured while the port is read and held otherwise.
  always_comb begin
    dOutActive_d = cfgSel && rd_i;
    dOut_d       = (cfgSel && rd_i) ? readData : dOut_q;
  end

  // Register file and read-data registers.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q        <= CFG_RST;
      dOut_q       <= 8'h00;
      dOutActive_q <= 1'b0;
    end else begin
      cfg_q        <= cfg_d;
      dOut_q       <= dOut_d;
      dOutActive_q <= dOutActive_d;
    end
  end

  assign d_out_o        = dOut_q;
  assign d_out_active_o = dOutActive_q;
  assign n_nmi_o        = nNmi_q;
  assign magic_mode_o   = magicMode_q;
  assign magic_map_o    = magicMap_q;
  assign cause_o        = cause_q;
  assign cfg_q_o        = cfg_q;

endmodule

// File: tb/tb_magic_nmi_ctrl.sv
// Directed, table-driven bench for magic_nmi_ctrl with hand-computed
// expectations, plus hand-written reset sequences.
module tb_magic_nmi_ctrl;

  localparam logic [95:0] CFG_INIT = {8'h1B, 8'h1A, 8'h19, 8'h18, 8'h17, 8'h16,
                                      8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
  localparam logic [3:0]  AUX      = 4'hA;

  // bus control encodings {mreq, ioreq, m1, rd, wr}
  localparam logic [4:0] C_IDLE = 5'b00000;
  localparam logic [4:0] C_MRD  = 5'b10010;
  localparam logic [4:0] C_M1RD = 5'b10110;
  localparam logic [4:0] C_IORD = 5'b01010;
  localparam logic [4:0] C_IOWR = 5'b01001;

  typedef struct {
    string       name;
    logic [4:0]  ctl;
    logic [15:0] a;
    logic [7:0]  d;
    logic        fe;
    logic [1:0]  req;
    logic [3:0]  expFlags;
    logic [2:0]  expCause;
    logic [7:0]  expDout;
    logic [7:0]  expCfg2;
  } vec_t;

  logic        clk28 = 1'b0;
  logic        rst_n;
  logic        mreq, ioreq, m1, rd, wr;
  logic [15:0] a;
  logic [7:0]  d;
  logic        nInt, nIntNext;
  logic [1:0]  req;
  logic [7:0]  dOut;
  logic        dOutActive, nNmi, magicMode, magicMap;
  logic [2:0]  cause;
  logic [95:0] cfgQ;

  int   testsRun = 0;
  int   testsFailed = 0;
  vec_t vecs[$];

  always #5 clk28 = ~clk28;

  magic_nmi_ctrl #(
    .NSRC(2), .NREG(12), .CFG_RST(CFG_INIT), .CFG_PORT(8'hFF), .SIG(8'hEB),
    .EXIT_A(16'hF000), .REMAP_A(16'hF008), .WDOG(3)
  ) dut (
    .clk28(clk28), .rst_n(rst_n),
    .mreq_i(mreq), .ioreq_i(ioreq), .m1_i(m1), .rd_i(rd), .wr_i(wr),
    .a_i(a), .d_i(d), .n_int_i(nInt), .n_int_next_i(nIntNext),
    .req_i(req), .aux_st_i(AUX),
    .d_out_o(dOut), .d_out_active_o(dOutActive), .n_nmi_o(nNmi),
    .magic_mode_o(magicMode), .magic_map_o(magicMap), .cause_o(cause),
    .cfg_q_o(cfgQ)
  );

  function automatic vec_t mk(string name, logic [4:0] ctl, logic [15:0] av,
                              logic [7:0] dv, logic fe, logic [1:0] rq,
                              logic [3:0] ex, logic [2:0] ec, logic [7:0] ed,
                              logic [7:0] e2);
    vec_t v;
    v.name = name; v.ctl = ctl; v.a = av; v.d = dv; v.fe = fe; v.req = rq;
    v.expFlags = ex; v.expCause = ec; v.expDout = ed; v.expCfg2 = e2;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    {mreq, ioreq, m1, rd, wr} = v.ctl;
    a        = v.a;
    d        = v.d;
    nInt     = 1'b1;
    nIntNext = ~v.fe;
    req      = v.req;
  endtask

  // expFlags = {n_nmi, magic_mode, magic_map, d_out_active}
  task automatic checkOutput(input vec_t v);
    logic [17:0] got, exp;
    got = {nNmi, magicMode, magicMap, dOutActive, cause, cfgQ[23:16]};
    exp = {v.expFlags, v.expCause, v.expCfg2};
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: {nmi,mode,map,act,cause,cfg2} got %h expected %h", v.name, got, exp);
    end
    if (v.expFlags[0]) begin
      testsRun++;
      if (dOut !== v.expDout) begin
        testsFailed++;
        $display("[TB] FAIL %s: d_out got %h expected %h", v.name, dOut, v.expDout);
      end
    end
  endtask

  task automatic runRows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk28);
      applyStimulus(vecs[i]);
      @(posedge clk28);
      #1;
      checkOutput(vecs[i]);
    end
  endtask

  task automatic checkResetState(input string name);
    testsRun++;
    if ({nNmi, magicMode, magicMap, dOutActive, cause} !== 7'b1110_000 || cfgQ !== CFG_INIT) begin
      testsFailed++;
      $display("[TB] FAIL %s: {nmi,mode,map,act,cause} got %b expected 1110000, cfg got %h expected %h",
               name, {nNmi, magicMode, magicMap, dOutActive, cause}, cfgQ, CFG_INIT);
    end
  endtask

  initial begin
    int splitIdx;
    // boot session with valid signature, exit trap
    vecs.push_back(mk("boot_sig_fetch", C_M1RD, 16'h0000, 8'hEB, 0, 2'b00, 4'b1110, 0, 0, 8'h12));
    vecs.push_back(mk("boot_active",    C_IDLE, 16'h0000, 8'h00, 0, 2'b00, 4'b1110, 0, 0, 8'h12));
    vecs.push_back(mk("boot_exit_trap", C_MRD,  16'hF000, 8'h00, 0, 2'b00, 4'b1010, 0, 0, 8'h12));
    vecs.push_back(mk("unmap_hold",     C_MRD,  16'hF000, 8'h00, 0, 2'b00, 4'b1010, 0, 0, 8'h12));
    vecs.push_back(mk("unmap_idle",     C_IDLE, 16'h0000, 8'h00, 0, 2'b00, 4'b1000, 0, 0, 8'h12));
    vecs.push_back(mk("unmapped_port",  C_IORD, 16'h00FF, 8'h00, 0, 2'b00, 4'b1000, 0, 0, 8'h12));
    // NMI entry with both sources requesting
    vecs.push_back(mk("fe_req11",       C_IDLE, 16'h0000, 8'h00, 1, 2'b11, 4'b0100, 0, 0, 8'h12));
    vecs.push_back(mk("pend_wait",      C_IDLE, 16'h0000, 8'h00, 0, 2'b00, 4'b0100, 0, 0, 8'h12));
    vecs.push_back(mk("entry_fetch",    C_M1RD, 16'h0066, 8'hEB, 0, 2'b00, 4'b1110, 0, 0, 8'h12));
    vecs.push_back(mk("entry_hold",     C_M1RD, 16'h0066, 8'hEB, 0, 2'b00, 4'b1110, 0, 0, 8'h12));
    vecs.push_back(mk("sig_ok",         C_IDLE, 16'h0000, 8'h00, 0, 2'b00, 4'b1110, 0, 0, 8'h12));
    vecs.push_back(mk("read_status",    C_IORD, 16'h00FF, 8'h00, 0, 2'b10, 4'b1111, 0, 8'hA1, 8'h12));
    vecs.push_back(mk("write_k3",       C_IOWR, 16'h03FF, 8'h5A, 0, 2'b00, 4'b1110, 0, 0, 8'h5A));
    vecs.push_back(mk("read_k3",        C_IORD, 16'h03FF, 8'h00, 0, 2'b00, 4'b1111, 0, 8'h5A, 8'h5A));
    vecs.push_back(mk("read_k32",       C_IORD, 16'h20FF, 8'h00, 0, 2'b00, 4'b1111, 0, 8'hFF, 8'h5A));
    vecs.push_back(mk("read_k12",       C_IORD, 16'h0CFF, 8'h00, 0, 2'b00, 4'b1111, 0, 8'h1B, 8'h5A));
    vecs.push_back(mk("write_k13",      C_IOWR, 16'h0DFF, 8'h77, 0, 2'b00, 4'b1110, 0, 0, 8'h5A));
    vecs.push_back(mk("read_k13",       C_IORD, 16'h0DFF, 8'h00, 0, 2'b00, 4'b1111, 0, 8'hFF, 8'h5A));
    vecs.push_back(mk("wrong_port",     C_IORD, 16'h03FE, 8'h00, 0, 2'b00, 4'b1110, 0, 0, 8'h5A));
    // remap trap and rearm without signature check
    vecs.push_back(mk("remap_trap",     C_MRD,  16'hF008, 8'h00, 0, 2'b00, 4'b1110, 0, 0, 8'h5A));
    vecs.push_back(mk("remap_unmap",    C_IDLE, 16'h0000, 8'h00, 0, 2'b00, 4'b1100, 0, 0, 8'h5A));
    vecs.push_back(mk("rearm_port_off", C_IORD, 16'h03FF, 8'h00, 0, 2'b00, 4'b1100, 0, 0, 8'h5A));
    vecs.push_back(mk("rearm_m1",       C_M1RD, 16'h1234, 8'h00, 0, 2'b00, 4'b1110, 0, 0, 8'h5A));
    vecs.push_back(mk("rearm_active",   C_IDLE, 16'h0000, 8'h00, 0, 2'b00, 4'b1110, 0, 0, 8'h5A));
    // exit trap coincident with a frame edge and pending request
    vecs.push_back(mk("exit_and_fe",    C_MRD,  16'hF000, 8'h00, 1, 2'b01, 4'b1010, 0, 0, 8'h5A));
    vecs.push_back(mk("exit_unmap",     C_IDLE, 16'h0000, 8'h00, 0, 2'b01, 4'b1000, 0, 0, 8'h5A));
    vecs.push_back(mk("no_queue",       C_IDLE, 16'h0000, 8'h00, 0, 2'b01, 4'b1000, 0, 0, 8'h5A));
    // watchdog expiry
    vecs.push_back(mk("fe_req10",       C_IDLE, 16'h0000, 8'h00, 1, 2'b10, 4'b0100, 1, 0, 8'h5A));
    vecs.push_back(mk("wd_wait",        C_IDLE, 16'h0000, 8'h00, 0, 2'b00, 4'b0100, 1, 0, 8'h5A));
    vecs.push_back(mk("wd_fe1",         C_IDLE, 16'h0000, 8'h00, 1, 2'b00, 4'b0100, 1, 0, 8'h5A));
    vecs.push_back(mk("wd_fe2",         C_IDLE, 16'h0000, 8'h00, 1, 2'b00, 4'b0100, 1, 0, 8'h5A));
    vecs.push_back(mk("wd_fe3_expire",  C_IDLE, 16'h0000, 8'h00, 1, 2'b00, 4'b1000, 1, 0, 8'h5A));
    vecs.push_back(mk("wd_idle",        C_IDLE, 16'h0000, 8'h00, 0, 2'b00, 4'b1000, 1, 0, 8'h5A));
    vecs.push_back(mk("fe_req01",       C_IDLE, 16'h0000, 8'h00, 1, 2'b01, 4'b0100, 0, 0, 8'h5A));
    splitIdx = vecs.size();
    // after mid-session reset: boot with a bad first opcode
    vecs.push_back(mk("bad_sig_fetch",  C_M1RD, 16'h0000, 8'h00, 0, 2'b00, 4'b1110, 0, 0, 8'h12));
    vecs.push_back(mk("bad_sig_hold",   C_M1RD, 16'h0000, 8'hEB, 0, 2'b00, 4'b1110, 0, 0, 8'h12));
    vecs.push_back(mk("bad_sig_exit",   C_IDLE, 16'h0000, 8'h00, 0, 2'b00, 4'b1000, 0, 0, 8'h12));
    vecs.push_back(mk("bad_sig_idle",   C_IDLE, 16'h0000, 8'h00, 0, 2'b00, 4'b1000, 0, 0, 8'h12));

    rst_n = 1'b0;
    applyStimulus(mk("init", C_IDLE, 16'h0000, 8'h00, 0, 2'b00, 4'b0, 0, 0, 8'h0));
    repeat (2) @(negedge clk28);
    checkResetState("reset_state");
    rst_n = 1'b1;

    runRows(0, splitIdx - 1);

    // asynchronous reset in the middle of a pending session
    @(negedge clk28);
    #2 rst_n = 1'b0;
    #1 checkResetState("async_reset_mid_session");
    @(negedge clk28);
    rst_n = 1'b1;

    runRows(splitIdx, vecs.size() - 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
